// File: rtl/eth_out_port_arb.sv
`default_nettype none
// ============================================================================
//  Module   : eth_out_port_arb
//  Purpose  : Packet-level round-robin arbiter that shares one switch output
//             port between ingress ports A and B. The grant is held from SOP
//             to EOP so packets never interleave. The output beat register
//             advances only while portStall is low.
//  Ports    : clk, reset (async, active-high)
//             inDataA/inSopA/inEopA/inValidA -> inReadyA   (ingress A)
//             inDataB/inSopB/inEopB/inValidB -> inReadyB   (ingress B)
//             portStall                                    (egress backpressure)
//             outData/outSop/outEop/outValid               (registered egress)
//             grantA/grantB    FSM in GRANT_A / GRANT_B
//             protoErr         pulse: non-SOP beat dropped in IDLE, or SOP
//                              seen mid-packet
//             wdErr            pulse: packet truncated at MAX_PKT_WORDS
//  Option   : `define ETH_ARB_WATCHDOG_EN enables the per-packet beat
//             watchdog; without it wdErr is tied 0 and any length passes.
//  Revision : 1.0 - initial release
// ============================================================================
module eth_out_port_arb #(
  parameter int DATA_W        = 32,
  parameter int MAX_PKT_WORDS = 384
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] inDataA,
  input  logic              inSopA,
  input  logic              inEopA,
  input  logic              inValidA,
  output logic              inReadyA,
  input  logic [DATA_W-1:0] inDataB,
  input  logic              inSopB,
  input  logic              inEopB,
  input  logic              inValidB,
  output logic              inReadyB,
  input  logic              portStall,
  output logic [DATA_W-1:0] outData,
  output logic              outSop,
  output logic              outEop,
  output logic              outValid,
  output logic              grantA,
  output logic              grantB,
  output logic              protoErr,
  output logic              wdErr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_b_q, last_b_d;   // 1: B was served last
  logic                first_q, first_d;     // next accepted beat opens the packet
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_sop_q, out_sop_d;
  logic                out_eop_q, out_eop_d;
  logic                out_valid_q, out_valid_d;
  logic                proto_q, proto_d;

  logic                ready_a, ready_b;
  logic                sel_b;
  logic                acc;
  logic [DATA_W-1:0]   acc_data;
  logic                acc_sop, acc_eop;
  logic                req_a, req_b;

`ifdef ETH_ARB_WATCHDOG_EN
  localparam int              CNT_W   = $clog2(MAX_PKT_WORDS) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_WORDS);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wd_q, wd_d;
`else
  logic                unused_max_w;
  assign unused_max_w = (MAX_PKT_WORDS > 0);
`endif

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    first_d     = first_q;
    ready_a     = 1'b0;
    ready_b     = 1'b0;
    proto_d     = 1'b0;
    acc         = 1'b0;
    acc_data    = inDataA;
    acc_sop     = 1'b0;
    acc_eop     = 1'b0;
    sel_b       = (state_q == GRANT_B);
    req_a       = inValidA & inSopA;
    req_b       = inValidB & inSopB;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_valid_d = out_valid_q;
`ifdef ETH_ARB_WATCHDOG_EN
    cnt_d       = cnt_q;
    wd_d        = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Non-SOP beats have no packet to belong to: swallow and flag them.
        // The SOP beat stays on the input until the grant is active.
        ready_a = inValidA & ~inSopA;
        ready_b = inValidB & ~inSopB;
        proto_d = ready_a | ready_b;
        first_d = 1'b1;
        if (req_a && (!req_b || last_b_q)) begin
          state_d = GRANT_A;
        end else if (req_b) begin
          state_d = GRANT_B;
        end
      end

      GRANT_A, GRANT_B: begin
        ready_a  = ~sel_b & ~portStall;
        ready_b  =  sel_b & ~portStall;
        acc      = (sel_b ? inValidB : inValidA) & ~portStall;
        acc_data = sel_b ? inDataB : inDataA;
        acc_sop  = sel_b ? inSopB  : inSopA;
        acc_eop  = sel_b ? inEopB  : inEopA;
        if (acc) begin
          first_d = 1'b0;
          // A repeated SOP inside a packet is forwarded as-is but reported.
          if (acc_sop && !first_q) begin
            proto_d = 1'b1;
          end
`ifdef ETH_ARB_WATCHDOG_EN
          cnt_d = first_q ? CNT_W'(1) : cnt_q + CNT_W'(1);
          if (!acc_eop && cnt_d == CNT_MAX) begin
            acc_eop = 1'b1;   // truncate: close the packet on this beat
            wd_d    = 1'b1;
          end
`endif
          if (acc_eop) begin
            last_b_d = sel_b;
            state_d  = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Output register only advances when the egress port is not stalled.
    if (!portStall) begin
      out_valid_d = acc;
      out_data_d  = acc ? acc_data : out_data_q;
      out_sop_d   = acc & acc_sop;
      out_eop_d   = acc & acc_eop;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      first_q     <= 1'b1;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_valid_q <= 1'b0;
      proto_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      first_q     <= first_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_valid_q <= out_valid_d;
      proto_q     <= proto_d;
    end
  end

`ifdef ETH_ARB_WATCHDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      wd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wd_q  <= wd_d;
    end
  end
  assign wdErr = wd_q;
`else
  assign wdErr = 1'b0;
`endif

  // Handshakes are held low while reset is asserted.
  assign inReadyA = ready_a & ~reset;
  assign inReadyB = ready_b & ~reset;
  assign outData  = out_data_q;
  assign outSop   = out_sop_q;
  assign outEop   = out_eop_q;
  assign outValid = out_valid_q;
  assign grantA   = (state_q == GRANT_A);
  assign grantB   = (state_q == GRANT_B);
  assign protoErr = proto_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_out_port_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_out_port_arb
//  Purpose  : Scoreboard bench for eth_out_port_arb. Stimulus pushes the
//             expected egress beats (ordered by a packet-level round-robin
//             model) into a queue; a monitor pops and compares each beat the
//             egress port takes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eth_out_port_arb;

  localparam int DW   = 32;
  localparam int MAXW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] inDataA, inDataB;
  logic          inSopA, inEopA, inValidA, inReadyA;
  logic          inSopB, inEopB, inValidB, inReadyB;
  logic          portStall;
  logic [DW-1:0] outData;
  logic          outSop, outEop, outValid;
  logic          grantA, grantB, protoErr, wdErr;

  eth_out_port_arb #(.DATA_W(DW), .MAX_PKT_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset),
    .inDataA(inDataA), .inSopA(inSopA), .inEopA(inEopA), .inValidA(inValidA), .inReadyA(inReadyA),
    .inDataB(inDataB), .inSopB(inSopB), .inEopB(inEopB), .inValidB(inValidB), .inReadyB(inReadyB),
    .portStall(portStall),
    .outData(outData), .outSop(outSop), .outEop(outEop), .outValid(outValid),
    .grantA(grantA), .grantB(grantB), .protoErr(protoErr), .wdErr(wdErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0, n_err = 0;
  int    cyc = 0, perr_cnt = 0, wd_cnt = 0, last_eop_cyc = 0;
  bit    last_b = 1'b1;   // model: 1 means B was served last
  bit    abort = 1'b0, stall_en = 1'b0, gap_chk = 1'b0, gap_armed = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (stall_en) portStall = ($urandom_range(0, 3) == 0);
  end

  // Monitor: the egress port takes a beat in every cycle with outValid & ~portStall.
  always @(negedge clk) begin
    if (!reset) begin
      if (protoErr) perr_cnt++;
      if (wdErr)    wd_cnt++;
      chk("ready_exclusive", {inReadyA, inReadyB} == 2'b11, 0);
      if (!outValid) chk("idle_flags", {outSop, outEop}, 0);
      if (outValid && !portStall) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_beat: actual=%0h required=none", outData);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_data", outData, e.d);
          chk("out_sop", outSop, e.s);
          chk("out_eop", outEop, e.e);
          if (outSop && gap_chk && gap_armed) chk("pkt_gap", cyc - last_eop_cyc, 2);
          if (outEop) begin
            gap_armed    = 1'b1;
            last_eop_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic drive(input int p, input logic v, input logic [DW-1:0] d, input logic s, input logic e);
    if (p == 0) begin
      inValidA = v; inDataA = d; inSopA = s; inEopA = e;
    end else begin
      inValidB = v; inDataB = d; inSopB = s; inEopB = e;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? inReadyA : inReadyB;
  endfunction

  // Presents one packet on port p, holding each beat until it is taken.
  task automatic send_pkt(input int p, input int len, input logic [DW-1:0] base,
                          input bit with_sop, input bit gaps);
    for (int i = 0; i < len; i++) begin
      bit done;
      int t;
      if (abort) break;
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        drive(p, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
      end
      drive(p, 1'b1, base + DW'(i), with_sop && i == 0, i == len - 1);
      done = 1'b0;
      t    = 0;
      while (!done && !abort) begin
        @(negedge clk);
        if (rdy(p)) done = 1'b1;
        else begin
          t++;
          if (t > 400) begin
            n_cmp++; n_err++;
            $display("FAIL handshake_timeout: port=%0d beat=%0d", p, i);
            abort = 1'b1;
          end
        end
      end
      if (!done) break;
      @(posedge clk); #1;
    end
    drive(p, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Reference: a packet leaves whole; the watchdog build cuts it at MAXW beats.
  task automatic push_pkt(input int len, input logic [DW-1:0] base);
    int n;
`ifdef ETH_ARB_WATCHDOG_EN
    n = (len > MAXW) ? MAXW : len;
`else
    n = len;
`endif
    for (int i = 0; i < n; i++) exp_q.push_back({base + DW'(i), i == 0, i == n - 1});
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk); t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: actual=%0d beats left required=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // mode 0: A only, 1: B only, 2: both request in the same cycle.
  task automatic round(input int mode, input int la, input int lb, input bit gaps);
    logic [DW-1:0] ba, bb;
    ba = $urandom();
    bb = $urandom();
    if (mode == 2) begin
      if (last_b) begin push_pkt(la, ba); push_pkt(lb, bb); last_b = 1'b1; end
      else        begin push_pkt(lb, bb); push_pkt(la, ba); last_b = 1'b0; end
    end else if (mode == 0) begin
      push_pkt(la, ba); last_b = 1'b0;
    end else begin
      push_pkt(lb, bb); last_b = 1'b1;
    end
    gap_armed = 1'b0;
    fork
      begin if (mode != 1) send_pkt(0, la, ba, 1'b1, gaps); end
      begin if (mode != 0) send_pkt(1, lb, bb, 1'b1, gaps); end
    join
    wait_drain();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset  = 1'b0;
    last_b = 1'b1;
  endtask

  initial begin
    int p0, w0, t;
    reset = 1'b1; portStall = 1'b0;
    drive(0, 1'b0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outValid", outValid, 0);
    chk("rst_outSop_outEop", {outSop, outEop}, 0);
    chk("rst_grants", {grantA, grantB}, 0);
    chk("rst_errs", {protoErr, wdErr}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Single A packet: grant latency, SOP latency, contiguous beats.
    push_pkt(4, 32'hA0);
    last_b = 1'b0;
    fork
      send_pkt(0, 4, 32'hA0, 1'b1, 1'b0);
      begin
        @(negedge clk);
        chk("t1_no_grant_yet", grantA, 0);
        @(negedge clk);
        chk("t1_grantA", grantA, 1);
        @(negedge clk);
        chk("t1_sop_latency", {outValid, outSop, outData}, {2'b11, 32'hA0});
        repeat (3) begin
          @(negedge clk);
          chk("t1_contiguous", outValid, 1);
        end
        chk("t1_eop", {outEop, outData}, {1'b1, 32'hA3});
        @(negedge clk);
        chk("t1_back_idle", {outValid, grantA}, 0);
      end
    join
    wait_drain();

    // Simultaneous requests twice: A, B, A, B with one bubble between packets.
    do_reset();
    gap_chk = 1'b1;
    round(2, 2, 2, 1'b0);
    round(2, 2, 2, 1'b0);
    gap_chk = 1'b0;

    // Stall for 3 cycles while beat 2 of a 5-beat packet is on the output.
    push_pkt(5, 32'h30);
    last_b = 1'b0;
    fork
      send_pkt(0, 5, 32'h30, 1'b1, 1'b0);
      begin
        t = 0;
        while (!(outValid && outData == 32'h30) && t < 50) begin
          @(negedge clk); t++;
        end
        chk("t3_reached_beat1", t < 50, 1);
        @(posedge clk); #1;
        portStall = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("t3_hold_beat2", {outValid, outData}, {1'b1, 32'h31});
          chk("t3_readyA_low", inReadyA, 0);
          @(posedge clk); #1;
        end
        portStall = 1'b0;
      end
    join
    wait_drain();

    // Non-SOP beat on B while idle.
    p0 = perr_cnt;
    drive(1, 1'b1, 32'h55, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_readyB", inReadyB, 1);
    @(posedge clk); #1;
    drive(1, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_protoErr", protoErr, 1);
    chk("t4_no_output", {outValid, grantB}, 0);
    @(negedge clk);
    chk("t4_pulse_ends", protoErr, 0);
    @(posedge clk); #1;
    chk("t4_perr_count", perr_cnt - p0, 1);

`ifdef ETH_ARB_WATCHDOG_EN
    // Over-long packet is cut at MAXW beats; the tail is discarded.
    p0 = perr_cnt;
    w0 = wd_cnt;
    push_pkt(10, 32'h80);
    last_b = 1'b0;
    send_pkt(0, 10, 32'h80, 1'b1, 1'b0);
    wait_drain();
    @(posedge clk); #1;
    chk("t5_wdErr_count", wd_cnt - w0, 1);
    chk("t5_tail_perr", perr_cnt - p0, 2);
`endif

    // Reset in the middle of a 6-beat packet.
    push_pkt(6, 32'h60);
    fork
      send_pkt(0, 6, 32'h60, 1'b1, 1'b0);
      begin
        t = 0;
        while (!(outValid && outData == 32'h62) && t < 50) begin
          @(negedge clk); t++;
        end
        chk("t6_reached_beat3", t < 50, 1);
        #1;
        abort = 1'b1;
        reset = 1'b1;
        #1;
        chk("t6_out_cleared", {outValid, outSop, outEop, outData}, 0);
        chk("t6_ctrl_cleared", {grantA, grantB, protoErr, wdErr, inReadyA}, 0);
      end
    join
    exp_q.delete();
    @(posedge clk); #1;
    reset  = 1'b0;
    abort  = 1'b0;
    last_b = 1'b1;
    p0 = perr_cnt;
    send_pkt(0, 3, 32'h63, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_tail_perr", perr_cnt - p0, 3);
    round(1, 1, 4, 1'b0);

    // Randomized rounds with backpressure and source gaps.
    p0 = perr_cnt;
    stall_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      round($urandom_range(0, 2), $urandom_range(1, 6), $urandom_range(1, 6), 1'b1);
    end
    stall_en = 1'b0;
    @(posedge clk); #1;
    portStall = 1'b0;
    wait_drain();
    chk("rand_no_protoErr", perr_cnt - p0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
